// File: rtl/cla_seq_divider.sv
// rtl/cla_seq_divider.sv - unsigned restoring divider, one quotient bit per clock on a cla_4b subtract chain
// Optional build macro: CLA_SEQ_DIVIDER_ABORT_EN adds an abort input that cancels a running division.

module cla_4b (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] s_o,
   output logic       c_o
);
   logic [3:0] g, p;
   logic [4:0] c;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;
   assign c[0] = c_i;
   assign c[1] = g[0] | (p[0] & c_i);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c_i);
   assign s_o = p ^ c[3:0];
   assign c_o = c[4];
endmodule

module cla_seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef CLA_SEQ_DIVIDER_ABORT_EN
   input  logic             abort,
`endif
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int NB = WIDTH / 4;
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, r_q, r_d, qw_q, qw_d;
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
   logic             dz_q, dz_d;

   logic [WIDTH-1:0] s_low, diff, r_next;
   logic [NB:0]      carry;
   logic             success;

   // Low WIDTH bits of {R, next dividend bit}; the dropped bit is r_q[WIDTH-1].
   assign s_low    = {r_q[WIDTH-2:0], dvd_q[WIDTH-1]};
   assign carry[0] = 1'b1;

   for (genvar i = 0; i < NB; i++) begin : g_cla
      cla_4b u_cla (
         .a_i(s_low[4*i +: 4]),
         .b_i(~dvs_q[4*i +: 4]),
         .c_i(carry[i]),
         .s_o(diff[4*i +: 4]),
         .c_o(carry[i+1])
      );
   end

   assign success = r_q[WIDTH-1] | carry[NB];
   assign r_next  = success ? diff : s_low;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      r_d     = r_q;
      qw_d    = qw_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor != '0) begin
                  dvd_d   = dividend;
                  dvs_d   = divisor;
                  r_d     = '0;
                  qw_d    = '0;
                  cnt_d   = CW'(WIDTH - 1);
                  dz_d    = 1'b0;
                  state_d = CALC;
               end else begin
                  quo_d   = '1;
                  rem_d   = dividend;
                  dz_d    = 1'b1;
                  state_d = FIN;
               end
            end
         end
         CALC: begin
`ifdef CLA_SEQ_DIVIDER_ABORT_EN
            if (abort) begin
               state_d = IDLE;
            end else begin
`else
            begin
`endif
               r_d   = r_next;
               qw_d  = {qw_q[WIDTH-2:0], success};
               dvd_d = dvd_q << 1;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  quo_d   = {qw_q[WIDTH-2:0], success};
                  rem_d   = r_next;
                  state_d = FIN;
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         r_q     <= '0;
         qw_q    <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         r_q     <= r_d;
         qw_q    <= qw_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
      end
   end

   assign busy        = (state_q == CALC);
   assign done        = (state_q == FIN);
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dz_q;
endmodule

// File: tb/tb_cla_seq_divider.sv
// tb/tb_cla_seq_divider.sv - table-driven and scoreboard bench for cla_seq_divider (WIDTH=8)
// Abort sequence is built only when CLA_SEQ_DIVIDER_ABORT_EN is defined.
module tb_cla_seq_divider;
   localparam int W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int   tests = 0;
   int   failed = 0;
   int   done_cnt = 0;
   vec_t sb[$];
   vec_t tbl[12];
   vec_t e;

   always #5 clk = ~clk;

   cla_seq_divider #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
`ifdef CLA_SEQ_DIVIDER_ABORT_EN
      .abort(abort),
`endif
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            check("quotient", int'(quotient), int'(e.q));
            check("remainder", int'(remainder), int'(e.r));
            check("div_by_zero", int'(div_by_zero), int'(e.dz));
         end
      end
   end

   // Called at negedge+1 in IDLE; returns at negedge+1 of the IDLE cycle after done.
   task automatic do_div(input vec_t v);
      int n;
      int d0;
      bit busy_ok;
      dividend = v.a;
      divisor  = v.b;
      start    = 1'b1;
      sb.push_back(v);
      d0 = done_cnt;
      @(negedge clk); #1;
      start   = 1'b0;
      n       = 1;
      busy_ok = 1'b1;
      while (!done && n < 40) begin
         if (!busy) busy_ok = 1'b0;
         @(negedge clk); #1;
         n++;
      end
      check("latency", n, v.dz ? 1 : W + 1);
      check("busy_during_calc", int'(busy_ok), 1);
      check("busy_at_done", int'(busy), 0);
      @(negedge clk); #1;
      check("done_pulses", done_cnt - d0, 1);
      check("done_low_after", int'(done), 0);
   endtask

   initial begin
      vec_t v;
      int   n;
      int   d0;
      tbl[0]  = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
      tbl[1]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
      tbl[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
      tbl[3]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
      tbl[4]  = '{8'd100, 8'd0,   8'd255, 8'd100, 1'b1};
      tbl[5]  = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0};
      tbl[6]  = '{8'd0,   8'd1,   8'd0,   8'd0,   1'b0};
      tbl[7]  = '{8'd255, 8'd16,  8'd15,  8'd15,  1'b0};
      tbl[8]  = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0};
      tbl[9]  = '{8'd128, 8'd3,   8'd42,  8'd2,   1'b0};
      tbl[10] = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1};
      tbl[11] = '{8'd254, 8'd127, 8'd2,   8'd0,   1'b0};

      @(posedge clk);
      @(posedge clk);
      @(negedge clk); rst = 1'b0; #1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_quotient", int'(quotient), 0);
      check("rst_remainder", int'(remainder), 0);
      check("rst_dz", int'(div_by_zero), 0);

      foreach (tbl[i]) do_div(tbl[i]);

      for (int i = 0; i < 10; i++) begin
         v.a  = W'($urandom_range(0, 255));
         v.b  = W'($urandom_range(1, 255));
         v.q  = v.a / v.b;
         v.r  = v.a % v.b;
         v.dz = 1'b0;
         do_div(v);
      end

      // second start during CALC is ignored; operand changes after capture have no effect
      dividend = 8'd200; divisor = 8'd7; start = 1'b1;
      sb.push_back('{8'd200, 8'd7, 8'd28, 8'd4, 1'b0});
      d0 = done_cnt;
      @(negedge clk); #1; start = 1'b0;
      @(negedge clk); #1;
      dividend = 8'd50; divisor = 8'd5; start = 1'b1;
      @(negedge clk); #1; start = 1'b0; dividend = 8'd13;
      n = 3;
      while (!done && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      check("ignored_start_latency", n, W + 1);
      @(negedge clk); #1;
      check("ignored_start_pulses", done_cnt - d0, 1);

      // synchronous reset mid-CALC abandons the operation
      dividend = 8'd200; divisor = 8'd7; start = 1'b1;
      @(negedge clk); #1; start = 1'b0;
      @(negedge clk); #1;
      @(negedge clk); #1;
      rst = 1'b1;
      @(negedge clk); #1; rst = 1'b0;
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_quotient", int'(quotient), 0);
      check("midrst_remainder", int'(remainder), 0);
      check("midrst_dz", int'(div_by_zero), 0);
      d0 = done_cnt;
      repeat (12) begin @(negedge clk); #1; end
      check("midrst_no_done", done_cnt - d0, 0);
      do_div('{8'd13, 8'd4, 8'd3, 8'd1, 1'b0});

`ifdef CLA_SEQ_DIVIDER_ABORT_EN
      do_div('{8'd200, 8'd7, 8'd28, 8'd4, 1'b0});
      dividend = 8'd13; divisor = 8'd4; start = 1'b1;
      d0 = done_cnt;
      @(negedge clk); #1; start = 1'b0;
      repeat (3) begin @(negedge clk); #1; end
      abort = 1'b1;
      @(negedge clk); #1; abort = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_quotient", int'(quotient), 28);
      check("abort_remainder", int'(remainder), 4);
      check("abort_dz", int'(div_by_zero), 0);
      repeat (12) begin @(negedge clk); #1; end
      check("abort_no_done", done_cnt - d0, 0);
`endif

      check("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
